// File: rtl/mem_stage_pipe.sv
// ============================================================================
// mem_stage_pipe
// ----------------------------------------------------------------------------
// RV32 memory stage with an internal word-organised data memory, followed by
// the MEM/WB pipeline register.
//
// Supports byte, halfword and word loads and stores (signed and unsigned
// loads). Each access takes MEM_LATENCY extra cycles, and the stage holds
// upstream with stall_m during those cycles. flush_m kills the instruction
// currently in the stage, including one that is part-way through its wait.
//
// Handshake: an M-stage instruction is offered when in_valid = 1. When
// stall_m = 1, upstream must hold every M input unchanged in the next cycle.
// The instruction is consumed at the first rising edge where stall_m = 0.
// stall_m never depends on anything except the current M inputs and the
// internal wait state. flush_m is the only input that may change while the
// stage is stalled.
//
// Parameters
//   DEPTH        data memory size in 32-bit words (power of two, >= 4)
//   MEM_LATENCY  extra cycles per load/store access (0..15)
//   AW           word-address width, derived from DEPTH
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   in_valid, flush_m       M-stage valid, synchronous kill of M instruction
//   RegWriteM .. WriteDataM M-stage control and data
//   stall_m                 upstream must hold M inputs this cycle
//   valid_w .. fault_w      registered W-stage entry
//   fsm_state               current access state (0 = IDLE, 1 = WAIT)
// ============================================================================
module mem_stage_pipe #(
    parameter int DEPTH       = 64,
    parameter int MEM_LATENCY = 0,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        flush_m,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic        stall_m,
    output logic        valid_w,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        fault_w,
    output logic [0:0]  fsm_state
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_stage_pipe: DEPTH must be a power of two and at least 4");
    end
    if (MEM_LATENCY < 0 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_stage_pipe: MEM_LATENCY must be in the range 0..15");
    end

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------------
    // Decode: access classification and fault detection
    // ------------------------------------------------------------------------
    logic [1:0]    a_lo;
    logic [AW-1:0] widx;
    logic          is_mem;
    logic          bad_f3;
    logic          misaligned;
    logic          fault_cond;
    logic          fault_m;
    logic          acc;

    assign a_lo   = ALU_ResultM[1:0];
    // Upper address bits are ignored, so the address wraps modulo DEPTH.
    assign widx   = ALU_ResultM[AW+1:2];
    assign is_mem = MemReadM | MemWriteM;

    always_comb begin
        bad_f3     = (Funct3M == 3'b011) | (Funct3M == 3'b110) | (Funct3M == 3'b111);
        misaligned = 1'b0;
        case (Funct3M[1:0])
            2'b01:   misaligned = a_lo[0];
            2'b10:   misaligned = (a_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        fault_cond = bad_f3 | misaligned;
    end

    // A faulting load/store never touches memory; it retires in one cycle
    // as a flagged entry. Reset gates everything so that an asynchronous
    // reset cannot let a store slip through on the edge it overlaps.
    assign fault_m = ~reset & in_valid & ~flush_m & is_mem & fault_cond;
    assign acc     = ~reset & in_valid & ~flush_m & is_mem & ~fault_cond;

    // ------------------------------------------------------------------------
    // Completion and W-register load conditions
    // ------------------------------------------------------------------------
    logic complete;   // memory access finishes at the coming edge
    logic pass_thru;  // non-accessing valid instruction retires at the coming edge
    logic load_w;

    always_comb begin
        if (MEM_LATENCY == 0) begin
            complete = (state_q == IDLE) & acc;
        end else begin
            complete = (state_q == WAIT) & (cnt_q == 4'd0) & ~flush_m & ~reset;
        end
        pass_thru = ~reset & (state_q == IDLE) & in_valid & ~flush_m & ~acc;
        load_w    = complete | pass_thru;
    end

    // stall_m covers the issuing cycle plus every WAIT cycle except the last,
    // which is MEM_LATENCY cycles in total. A flush releases upstream at once.
    always_comb begin
        stall_m = 1'b0;
        if (!reset && !flush_m) begin
            if (state_q == IDLE) begin
                stall_m = acc & (MEM_LATENCY > 0);
            end else begin
                stall_m = (cnt_q != 4'd0);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (acc && (MEM_LATENCY > 0)) begin
                    state_d = WAIT;
                    cnt_d   = 4'(MEM_LATENCY - 1);
                end
            end
            WAIT: begin
                if (flush_m) begin
                    // Abort: the pending access is dropped, nothing is written.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fsm_state = state_q;

    // ------------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------------
    logic [31:0] mem [DEPTH];
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] ld_data;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mem_we;

    assign rword  = mem[widx];
    // Move the addressed lane down to bit 0 before extension.
    assign rshift = rword >> {a_lo, 3'b000};

    // Store lane selection: data is replicated across the word so that the
    // byte enables alone pick the destination lane(s).
    always_comb begin
        case (Funct3M[1:0])
            2'b00: begin
                be    = 4'b0001 << a_lo;
                wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be    = a_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = WriteDataM;
            end
        endcase
    end

    // Load extension: Funct3M[2] selects unsigned (BU/HU).
    always_comb begin
        case (Funct3M[1:0])
            2'b00:   ld_data = {{24{~Funct3M[2] & rshift[7]}},  rshift[7:0]};
            2'b01:   ld_data = {{16{~Funct3M[2] & rshift[15]}}, rshift[15:0]};
            default: ld_data = rword;
        endcase
    end

    // Stores commit only on the completion edge.
    assign mem_we = complete & MemWriteM;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------------
    // Every edge that is not a completion or a pass-through loads a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_w     <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            fault_w     <= 1'b0;
        end else if (load_w) begin
            valid_w     <= 1'b1;
            RegWriteW   <= RegWriteM & ~fault_m;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (complete & MemReadM) ? ld_data : 32'd0;
            fault_w     <= fault_m;
        end else begin
            valid_w     <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            fault_w     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// ============================================================================
// tb_mem_stage_pipe
// ----------------------------------------------------------------------------
// Directed bench for mem_stage_pipe. Three instances share the M-stage
// buses (each with its own in_valid): index 0 has MEM_LATENCY = 0, index 1
// has MEM_LATENCY = 3 and index 2 has MEM_LATENCY = 2. All have DEPTH = 64.
// ============================================================================
module tb_mem_stage_pipe;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------------
    logic [2:0]  in_valid_a;
    logic        flush_m;
    logic        RegWriteM, MemWriteM, MemReadM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;

    logic [2:0]       stall_a, valid_a, regw_a, fault_a, state_a;
    logic [2:0][1:0]  rsrc_a;
    logic [2:0][4:0]  rd_a;
    logic [2:0][31:0] pc_a, alu_a, rdata_a;

    mem_stage_pipe #(.DEPTH(64), .MEM_LATENCY(0)) u_l0 (
        .clock(clock), .reset(reset), .in_valid(in_valid_a[0]), .flush_m(flush_m),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .stall_m(stall_a[0]), .valid_w(valid_a[0]), .RegWriteW(regw_a[0]),
        .ResultSrcW(rsrc_a[0]), .RD_W(rd_a[0]), .PCPlus4W(pc_a[0]),
        .ALU_ResultW(alu_a[0]), .ReadDataW(rdata_a[0]), .fault_w(fault_a[0]),
        .fsm_state(state_a[0])
    );

    mem_stage_pipe #(.DEPTH(64), .MEM_LATENCY(3)) u_l3 (
        .clock(clock), .reset(reset), .in_valid(in_valid_a[1]), .flush_m(flush_m),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .stall_m(stall_a[1]), .valid_w(valid_a[1]), .RegWriteW(regw_a[1]),
        .ResultSrcW(rsrc_a[1]), .RD_W(rd_a[1]), .PCPlus4W(pc_a[1]),
        .ALU_ResultW(alu_a[1]), .ReadDataW(rdata_a[1]), .fault_w(fault_a[1]),
        .fsm_state(state_a[1])
    );

    mem_stage_pipe #(.DEPTH(64), .MEM_LATENCY(2)) u_l2 (
        .clock(clock), .reset(reset), .in_valid(in_valid_a[2]), .flush_m(flush_m),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .stall_m(stall_a[2]), .valid_w(valid_a[2]), .RegWriteW(regw_a[2]),
        .ResultSrcW(rsrc_a[2]), .RD_W(rd_a[2]), .PCPlus4W(pc_a[2]),
        .ALU_ResultW(alu_a[2]), .ReadDataW(rdata_a[2]), .fault_w(fault_a[2]),
        .fsm_state(state_a[2])
    );

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_w(input string tag, input int t, input logic v, input logic rw,
                           input logic f, input logic [31:0] rdata);
        check({tag, "_valid"}, 32'(valid_a[t]), 32'(v));
        check({tag, "_regw"},  32'(regw_a[t]),  32'(rw));
        check({tag, "_fault"}, 32'(fault_a[t]), 32'(f));
        check({tag, "_rdata"}, rdata_a[t], rdata);
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int t, input logic mw, input logic mr, input logic rw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        in_valid_a    = 3'b000;
        in_valid_a[t] = 1'b1;
        MemWriteM     = mw;
        MemReadM      = mr;
        RegWriteM     = rw;
        Funct3M       = f3;
        ALU_ResultM   = addr;
        WriteDataM    = data;
        #1;
    endtask

    // Holds the instruction until the stage lets it go, counting stall cycles,
    // then takes the completion edge and drops in_valid.
    task automatic complete_op(input int t, input int exp_stall, input string tag);
        int   n_stall = 0;
        logic saw_v   = 1'b0;
        for (int i = 0; i < 20 && stall_a[t]; i++) begin
            n_stall++;
            step();
            if (valid_a[t]) saw_v = 1'b1;
        end
        check({tag, "_stalls"}, 32'(n_stall), 32'(exp_stall));
        if (exp_stall > 0) check({tag, "_valid_in_stall"}, 32'(saw_v), 32'd0);
        step();
        in_valid_a = 3'b000;
        flush_m    = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset       = 1'b1;
        in_valid_a  = 3'b000;
        flush_m     = 1'b0;
        RegWriteM   = 1'b0;
        MemWriteM   = 1'b0;
        MemReadM    = 1'b0;
        ResultSrcM  = 2'b01;
        Funct3M     = 3'b010;
        RD_M        = 5'd3;
        PCPlus4M    = 32'h0000_0104;
        ALU_ResultM = 32'd0;
        WriteDataM  = 32'd0;

        repeat (2) @(posedge clock);
        #1;
        for (int t = 0; t < 3; t++) begin
            check($sformatf("rst%0d", t), {stall_a[t], state_a[t], valid_a[t], fault_a[t]}, 32'd0);
            check($sformatf("rst%0d_rdata", t), rdata_a[t], 32'd0);
        end
        reset = 1'b0;
        step();

        // ---------------- MEM_LATENCY = 0 ----------------
        issue(0, 1, 0, 0, 3'b010, 32'h10, 32'hDEADBEEF);
        complete_op(0, 0, "sw10");
        check_w("sw10", 0, 1, 0, 0, 32'd0);

        issue(0, 0, 1, 1, 3'b010, 32'h10, 32'd0);
        complete_op(0, 0, "lw10");
        check_w("lw10", 0, 1, 1, 0, 32'hDEADBEEF);
        check("lw10_rd",   32'(rd_a[0]),   32'd3);
        check("lw10_rsrc", 32'(rsrc_a[0]), 32'd1);
        check("lw10_pc",   pc_a[0],        32'h104);
        check("lw10_alu",  alu_a[0],       32'h10);

        issue(0, 1, 0, 0, 3'b010, 32'h20, 32'h0);
        complete_op(0, 0, "sw20");
        issue(0, 1, 0, 0, 3'b000, 32'h21, 32'h0000_0080);
        complete_op(0, 0, "sb21");
        issue(0, 0, 1, 1, 3'b000, 32'h21, 32'd0);
        complete_op(0, 0, "lb21");
        check("lb21", rdata_a[0], 32'hFFFF_FF80);
        issue(0, 0, 1, 1, 3'b100, 32'h21, 32'd0);
        complete_op(0, 0, "lbu21");
        check("lbu21", rdata_a[0], 32'h0000_0080);
        issue(0, 1, 0, 0, 3'b001, 32'h22, 32'h0000_8001);
        complete_op(0, 0, "sh22");
        issue(0, 0, 1, 1, 3'b001, 32'h22, 32'd0);
        complete_op(0, 0, "lh22");
        check("lh22", rdata_a[0], 32'hFFFF_8001);
        issue(0, 0, 1, 1, 3'b101, 32'h22, 32'd0);
        complete_op(0, 0, "lhu22");
        check("lhu22", rdata_a[0], 32'h0000_8001);
        issue(0, 0, 1, 1, 3'b010, 32'h20, 32'd0);
        complete_op(0, 0, "lw20");
        check("lw20", rdata_a[0], 32'h8001_8000);

        // Faults: misaligned LW, illegal funct3 store, misaligned SH
        issue(0, 0, 1, 1, 3'b010, 32'h12, 32'd0);
        complete_op(0, 0, "lw12");
        check_w("lw12", 0, 1, 0, 1, 32'd0);
        issue(0, 1, 0, 0, 3'b011, 32'h10, 32'h1111_1111);
        complete_op(0, 0, "s011");
        check_w("s011", 0, 1, 0, 1, 32'd0);
        issue(0, 1, 0, 0, 3'b001, 32'h11, 32'h0000_2222);
        complete_op(0, 0, "sh11");
        check("sh11_fault", 32'(fault_a[0]), 32'd1);
        issue(0, 0, 1, 1, 3'b010, 32'h10, 32'd0);
        complete_op(0, 0, "lw10b");
        check_w("lw10b", 0, 1, 1, 0, 32'hDEADBEEF);

        // Non-memory pass-through, flush in IDLE, idle bubble
        issue(0, 0, 0, 1, 3'b000, 32'h0000_1234, 32'd0);
        complete_op(0, 0, "add");
        check_w("add", 0, 1, 1, 0, 32'd0);
        check("add_alu", alu_a[0], 32'h1234);
        issue(0, 0, 0, 1, 3'b000, 32'h0000_5678, 32'd0);
        flush_m = 1'b1;
        #1;
        complete_op(0, 0, "flush0");
        check_w("flush0", 0, 0, 0, 0, 32'd0);
        check("flush0_alu", alu_a[0], 32'd0);
        step();
        check("idle_valid", 32'(valid_a[0]), 32'd0);

        // Address wrap
        issue(0, 1, 0, 0, 3'b010, 32'h100, 32'hA5A5_A5A5);
        complete_op(0, 0, "sw100");
        issue(0, 0, 1, 1, 3'b010, 32'h0, 32'd0);
        complete_op(0, 0, "lw0");
        check("wrap", rdata_a[0], 32'hA5A5_A5A5);

        // ---------------- MEM_LATENCY = 3 ----------------
        issue(1, 1, 0, 0, 3'b010, 32'h8, 32'hCAFE_F00D);
        complete_op(1, 3, "l3_sw");
        check_w("l3_sw", 1, 1, 0, 0, 32'd0);
        issue(1, 0, 1, 1, 3'b010, 32'h8, 32'd0);
        complete_op(1, 3, "l3_lw");
        check_w("l3_lw", 1, 1, 1, 0, 32'hCAFE_F00D);
        issue(1, 0, 0, 1, 3'b000, 32'h55, 32'd0);
        check("l3_add_stall", 32'(stall_a[1]), 32'd0);
        complete_op(1, 0, "l3_add");
        check_w("l3_add", 1, 1, 1, 0, 32'd0);
        check("l3_add_alu", alu_a[1], 32'h55);

        // ---------------- MEM_LATENCY = 2 ----------------
        issue(2, 1, 0, 0, 3'b010, 32'h4, 32'h1111_2222);
        complete_op(2, 2, "l2_sw");

        // Flush during the second cycle of a store
        issue(2, 1, 0, 0, 3'b010, 32'h4, 32'h1234_5678);
        step();
        check("l2_wait", 32'(state_a[2]), 32'd1);
        flush_m = 1'b1;
        step();
        check("l2_flush_state", 32'(state_a[2]), 32'd0);
        check_w("l2_flush", 2, 0, 0, 0, 32'd0);
        in_valid_a = 3'b000;
        flush_m    = 1'b0;
        issue(2, 0, 1, 1, 3'b010, 32'h4, 32'd0);
        complete_op(2, 2, "l2_lw_a");
        check("l2_after_flush", rdata_a[2], 32'h1111_2222);

        // Asynchronous reset during WAIT
        issue(2, 1, 0, 0, 3'b010, 32'h4, 32'h1234_5678);
        step();
        check("l2_wait2", 32'(state_a[2]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("l2_rst_state", 32'(state_a[2]), 32'd0);
        check("l2_rst_stall", 32'(stall_a[2]), 32'd0);
        check_w("l2_rst", 2, 0, 0, 0, 32'd0);
        in_valid_a = 3'b000;
        @(posedge clock);
        #1;
        reset = 1'b0;
        issue(2, 0, 1, 1, 3'b010, 32'h4, 32'd0);
        complete_op(2, 2, "l2_lw_b");
        check("l2_after_reset", rdata_a[2], 32'h1111_2222);

        // ---------------- Report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
